// File: rtl/btf_dif_gs.sv
// Gentleman-Sande DIF butterfly: out_a = (a+b) mod q, out_b = ((a-b) mod q)*w mod q.
// Latency: DELAY_ADDSUB+DELAY_MUL+DELAY_RED cycles (9), plus 1 with BTF_GS_DIV2_EN.
// Backpressure: none; stall=1 freezes every pipeline register, and input is ignored.
//
// Optional macro BTF_GS_DIV2_EN: adds an output stage that multiplies both results
// by 2^-1 mod q when the intt flag that accompanied the data was 1.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset (clears all registers)
//   stall             - global hold of data and valid pipelines
//   intt              - halving select (only with BTF_GS_DIV2_EN)
//   in_valid          - qualifies btf_in_a/b/w
//   btf_in_a/b/w      - operands and inverse twiddle, all < q
//   q, mu             - modulus and Barrett constant floor(2^(2*LOGQ)/q), static
//   out_valid         - qualifies btf_out_a/b
//   btf_out_a/b       - sum and difference-times-twiddle results
module btf_dif_gs #(
  parameter int LOGQ         = 14,
  parameter int DELAY_MUL    = 3,
  parameter int DELAY_RED    = 4,
  parameter int DELAY_ADDSUB = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            intt,
  input  logic            in_valid,
  input  logic [LOGQ-1:0] btf_in_a,
  input  logic [LOGQ-1:0] btf_in_b,
  input  logic [LOGQ-1:0] btf_in_w,
  input  logic [LOGQ-1:0] q,
  input  logic [LOGQ:0]   mu,
  output logic            out_valid,
  output logic [LOGQ-1:0] btf_out_a,
  output logic [LOGQ-1:0] btf_out_b
);

  localparam int CORE_LAT = DELAY_ADDSUB + DELAY_MUL + DELAY_RED;
`ifdef BTF_GS_DIV2_EN
  localparam int LATENCY = CORE_LAT + 1;
`else
  localparam int LATENCY = CORE_LAT;
`endif
  // sum waits through the multiplier and the first three reduction stages,
  // then lands in core_a together with core_b.
  localparam int SUM_DLY = DELAY_MUL + DELAY_RED - 1;

  if (DELAY_RED != 4 || DELAY_ADDSUB != 2) begin : g_cfg_check
    $error("btf_dif_gs: DELAY_RED must be 4 and DELAY_ADDSUB must be 2");
  end

  // Pipeline registers
  logic [LOGQ:0]     s1, d1;
  logic [LOGQ-1:0]   w1, sum2, diff2, w2;
  logic [2*LOGQ-1:0] mul_sr [DELAY_MUL];
  logic [LOGQ-1:0]   sum_sr [SUM_DLY];
  logic [2*LOGQ+1:0] t1;
  logic [2*LOGQ:0]   t2;
  logic [LOGQ+1:0]   x_r1, x_r2, r3;
  logic [LOGQ-1:0]   core_a, core_b;
  logic [LATENCY-1:0] vld_sr;

  // Combinational next-state values
  logic [LOGQ:0]     s1_n, d1_n, sum_full, diff_full;
  logic [2*LOGQ-1:0] x, mul_n;
  logic [2*LOGQ+1:0] t1_n;
  logic [2*LOGQ:0]   t2_n;
  logic [LOGQ+1:0]   r_n, red_n, q_x1, q_x2;

  always_comb begin
    s1_n      = {1'b0, btf_in_a} + {1'b0, btf_in_b};
    // Adding q first keeps the difference non-negative for in-range operands.
    d1_n      = {1'b0, btf_in_a} + {1'b0, q} - {1'b0, btf_in_b};
    sum_full  = (s1 >= {1'b0, q}) ? s1 - {1'b0, q} : s1;
    diff_full = (d1 >= {1'b0, q}) ? d1 - {1'b0, q} : d1;
    mul_n     = {{LOGQ{1'b0}}, diff2} * {{LOGQ{1'b0}}, w2};
    x         = mul_sr[DELAY_MUL-1];
    // Barrett quotient estimate: floor(floor(x/2^(LOGQ-1)) * mu / 2^(LOGQ+1)).
    t1_n      = {{(LOGQ+1){1'b0}}, x[2*LOGQ-1:LOGQ-1]} * {{(LOGQ+1){1'b0}}, mu};
    t2_n      = {{LOGQ{1'b0}}, t1[2*LOGQ+1:LOGQ+1]} * {{(LOGQ+1){1'b0}}, q};
    // The estimate undershoots by at most 2q, so r < 3q < 2^(LOGQ+2) and the
    // low LOGQ+2 bits of the difference are exact under wrap-around.
    r_n       = x_r2 - t2[LOGQ+1:0];
    q_x1      = {2'b00, q};
    q_x2      = {1'b0, q, 1'b0};
    if (r3 >= q_x2) begin
      red_n = r3 - q_x2;
    end else if (r3 >= q_x1) begin
      red_n = r3 - q_x1;
    end else begin
      red_n = r3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      d1     <= '0;
      w1     <= '0;
      sum2   <= '0;
      diff2  <= '0;
      w2     <= '0;
      for (int i = 0; i < DELAY_MUL; i++) mul_sr[i] <= '0;
      for (int i = 0; i < SUM_DLY; i++)   sum_sr[i] <= '0;
      t1     <= '0;
      t2     <= '0;
      x_r1   <= '0;
      x_r2   <= '0;
      r3     <= '0;
      core_a <= '0;
      core_b <= '0;
      vld_sr <= '0;
    end else if (!stall) begin
      // AS1
      s1     <= s1_n;
      d1     <= d1_n;
      w1     <= btf_in_w;
      // AS2
      sum2   <= sum_full[LOGQ-1:0];
      diff2  <= diff_full[LOGQ-1:0];
      w2     <= w1;
      // Multiplier pipeline and matching sum delay line
      mul_sr[0] <= mul_n;
      for (int i = 1; i < DELAY_MUL; i++) mul_sr[i] <= mul_sr[i-1];
      sum_sr[0] <= sum2;
      for (int i = 1; i < SUM_DLY; i++)   sum_sr[i] <= sum_sr[i-1];
      // R1..R4
      t1     <= t1_n;
      x_r1   <= x[LOGQ+1:0];
      t2     <= t2_n;
      x_r2   <= x_r1;
      r3     <= r_n;
      core_b <= red_n[LOGQ-1:0];
      core_a <= sum_sr[SUM_DLY-1];
      vld_sr <= {vld_sr[LATENCY-2:0], in_valid};
    end
  end

  assign out_valid = vld_sr[LATENCY-1];

`ifdef BTF_GS_DIV2_EN
  logic [CORE_LAT-1:0] intt_sr;
  logic [LOGQ-1:0]     half_a, half_b;
  logic [LOGQ:0]       ha_full, hb_full;

  // v/2 mod q: odd values get q added first (q odd makes the sum even).
  always_comb begin
    ha_full = {1'b0, core_a} + (core_a[0] ? {1'b0, q} : {(LOGQ+1){1'b0}});
    hb_full = {1'b0, core_b} + (core_b[0] ? {1'b0, q} : {(LOGQ+1){1'b0}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      intt_sr <= '0;
      half_a  <= '0;
      half_b  <= '0;
    end else if (!stall) begin
      intt_sr <= {intt_sr[CORE_LAT-2:0], intt};
      half_a  <= intt_sr[CORE_LAT-1] ? ha_full[LOGQ:1] : core_a;
      half_b  <= intt_sr[CORE_LAT-1] ? hb_full[LOGQ:1] : core_b;
    end
  end

  assign btf_out_a = half_a;
  assign btf_out_b = half_b;

  logic unused_div2;
  assign unused_div2 = ^{ha_full[0], hb_full[0]};
`else
  assign btf_out_a = core_a;
  assign btf_out_b = core_b;

  logic unused_intt;
  assign unused_intt = intt;
`endif

  // Bits of the Barrett intermediates that the algorithm never needs.
  logic unused_bits;
  assign unused_bits = ^{t1[LOGQ:0], t2[2*LOGQ:LOGQ+2], red_n[LOGQ+1:LOGQ],
                         sum_full[LOGQ], diff_full[LOGQ]};

endmodule

// File: tb/tb_btf_dif_gs.sv
module tb_btf_dif_gs;
  localparam int     LOGQ = 14;
  localparam longint Q    = 12289;
  localparam longint MU   = 21843;
  localparam longint INV2 = (Q + 1) / 2;
`ifdef BTF_GS_DIV2_EN
  localparam bit DIV2 = 1'b1;
  localparam int LAT  = 10;
`else
  localparam bit DIV2 = 1'b0;
  localparam int LAT  = 9;
`endif

  logic            clk = 1'b0;
  logic            rst, stall, intt, in_valid;
  logic [LOGQ-1:0] btf_in_a, btf_in_b, btf_in_w, q;
  logic [LOGQ:0]   mu;
  logic            out_valid;
  logic [LOGQ-1:0] btf_out_a, btf_out_b;

  btf_dif_gs dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .intt      (intt),
    .in_valid  (in_valid),
    .btf_in_a  (btf_in_a),
    .btf_in_b  (btf_in_b),
    .btf_in_w  (btf_in_w),
    .q         (q),
    .mu        (mu),
    .out_valid (out_valid),
    .btf_out_a (btf_out_a),
    .btf_out_b (btf_out_b)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: each accepted (unstalled) cycle enters a queue; the output
  // seen after that cycle is whatever entered LAT accepted cycles earlier.
  typedef struct packed {
    logic            vld;
    logic [LOGQ-1:0] a;
    logic [LOGQ-1:0] b;
  } exp_t;

  exp_t hist[$];
  exp_t m;

  function automatic longint halve(input longint v, input bit it);
    if (DIV2 && it) return (v * INV2) % Q;
    return v;
  endfunction

  function automatic logic [LOGQ-1:0] ref_a(input longint a, input longint b, input bit it);
    longint s;
    s = (a + b) % Q;
    return LOGQ'(halve(s, it));
  endfunction

  function automatic logic [LOGQ-1:0] ref_b(input longint a, input longint b,
                                            input longint w, input bit it);
    longint d;
    d = ((a - b + Q) % Q) * w % Q;
    return LOGQ'(halve(d, it));
  endfunction

  // Drive one cycle of inputs, advance one clock, then update the model.
  task automatic step(input logic v, input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b,
                      input logic [LOGQ-1:0] w, input logic it, input logic st, input logic r);
    exp_t e;
    rst      = r;
    stall    = st;
    in_valid = v;
    btf_in_a = a;
    btf_in_b = b;
    btf_in_w = w;
    intt     = it;
    @(posedge clk);
    #1;
    if (r) begin
      hist.delete();
      for (int i = 0; i < LAT - 1; i++) hist.push_back('0);
      m = '0;
    end else if (!st) begin
      e.vld = v;
      e.a   = ref_a(a, b, it);
      e.b   = ref_b(a, b, w, it);
      hist.push_back(e);
      m = hist.pop_front();
    end
  endtask

  function automatic logic [LOGQ-1:0] rnd_val();
    return LOGQ'($urandom_range(0, 12288));
  endfunction

  task automatic test_reset();
    // Reset must win over stall.
    step(1, 14'd7, 14'd1, 14'd3, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_vld: got %0b want 0", out_valid);
    end
    n_vec++;
    if (btf_out_a !== '0) begin
      n_err++; $display("FAIL reset_out_a: got %0d want 0", btf_out_a);
    end
    n_vec++;
    if (btf_out_b !== '0) begin
      n_err++; $display("FAIL reset_out_b: got %0d want 0", btf_out_b);
    end
    for (int k = 0; k < LAT + 2; k++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_idle_vld step %0d: got %0b want 0", k, out_valid);
      end
    end
  endtask

  typedef struct packed {
    logic [LOGQ-1:0] a, b, w;
    logic            it;
    logic [LOGQ-1:0] ea, eb;
  } dir_t;

  task automatic test_directed();
    dir_t tbl[$];
`ifdef BTF_GS_DIV2_EN
    tbl.push_back('{a:14'd5, b:14'd3, w:14'd2, it:1'b1, ea:14'd4,    eb:14'd2});
    tbl.push_back('{a:14'd3, b:14'd0, w:14'd1, it:1'b1, ea:14'd6146, eb:14'd6146});
    tbl.push_back('{a:14'd5, b:14'd3, w:14'd2, it:1'b0, ea:14'd8,    eb:14'd4});
    tbl.push_back('{a:14'd12288, b:14'd0, w:14'd12288, it:1'b0, ea:14'd12288, eb:14'd1});
`else
    tbl.push_back('{a:14'd5, b:14'd3, w:14'd2, it:1'b0, ea:14'd8, eb:14'd4});
    tbl.push_back('{a:14'd3, b:14'd5, w:14'd1, it:1'b0, ea:14'd8, eb:14'd12287});
    tbl.push_back('{a:14'd12288, b:14'd12288, w:14'd12288, it:1'b0, ea:14'd12287, eb:14'd0});
    tbl.push_back('{a:14'd12288, b:14'd0, w:14'd12288, it:1'b0, ea:14'd12288, eb:14'd1});
    tbl.push_back('{a:14'd777, b:14'd777, w:14'd4321, it:1'b1, ea:14'd1554, eb:14'd0});
`endif
    foreach (tbl[i]) begin
      step(1, tbl[i].a, tbl[i].b, tbl[i].w, tbl[i].it, 0, 0);
      for (int k = 2; k <= LAT + 1; k++) begin
        step(0, 0, 0, 0, 0, 0, 0);
        if (k == LAT - 1 || k == LAT + 1) begin
          n_vec++;
          if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL dir%0d_vld_edge k=%0d: got %0b want 0", i, k, out_valid);
          end
        end
        if (k == LAT) begin
          n_vec++;
          if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL dir%0d_vld: got %0b want 1", i, out_valid);
          end
          n_vec++;
          if (btf_out_a !== tbl[i].ea) begin
            n_err++; $display("FAIL dir%0d_out_a: got %0d want %0d", i, btf_out_a, tbl[i].ea);
          end
          n_vec++;
          if (btf_out_b !== tbl[i].eb) begin
            n_err++; $display("FAIL dir%0d_out_b: got %0d want %0d", i, btf_out_b, tbl[i].eb);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10000 + LAT + 2; i++) begin
      if (i < 10000) step(1, rnd_val(), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 0, 0);
      else           step(0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (out_valid !== m.vld) begin
        n_err++; $display("FAIL b2b_vld step %0d: got %0b want %0b", i, out_valid, m.vld);
      end
      if (m.vld) begin
        n_vec++;
        if (btf_out_a !== m.a || btf_out_b !== m.b) begin
          n_err++;
          $display("FAIL b2b_data step %0d: got a=%0d b=%0d want a=%0d b=%0d",
                   i, btf_out_a, btf_out_b, m.a, m.b);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [LOGQ-1:0] va[4], vb[4], vw[4];
    int vi[$];
    bit ss[$];
    for (int i = 0; i < 4; i++) begin
      va[i] = rnd_val(); vb[i] = rnd_val(); vw[i] = rnd_val();
    end
    // Stall while v2 is held at the input, then stall again as results emerge.
    vi = '{0, 1, 2, 2, 2, 2, 3};
    ss = '{0, 0, 1, 1, 1, 0, 0};
    for (int j = 0; j < LAT + 6; j++) begin
      vi.push_back(-1);
      ss.push_back(j >= 4 && j <= 6);
    end
    // Random stall/valid mix.
    for (int j = 0; j < 300; j++) begin
      vi.push_back(($urandom_range(0, 3) == 0) ? -1 : 4);
      ss.push_back($urandom_range(0, 3) == 0);
    end
    for (int j = 0; j < LAT + 2; j++) begin
      vi.push_back(-1);
      ss.push_back(1'b0);
    end
    foreach (vi[i]) begin
      if (vi[i] < 0)      step(0, 0, 0, 0, 0, ss[i], 0);
      else if (vi[i] < 4) step(1, va[vi[i]], vb[vi[i]], vw[vi[i]], 0, ss[i], 0);
      else                step(1, rnd_val(), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), ss[i], 0);
      n_vec++;
      if (out_valid !== m.vld) begin
        n_err++; $display("FAIL stall_vld step %0d: got %0b want %0b", i, out_valid, m.vld);
      end
      if (m.vld) begin
        n_vec++;
        if (btf_out_a !== m.a || btf_out_b !== m.b) begin
          n_err++;
          $display("FAIL stall_data step %0d: got a=%0d b=%0d want a=%0d b=%0d",
                   i, btf_out_a, btf_out_b, m.a, m.b);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1, rnd_val(), rnd_val(), rnd_val(), 0, 0, 0);
    step(1, rnd_val(), rnd_val(), rnd_val(), 0, 0, 1);
    n_vec++;
    if (out_valid !== 1'b0 || btf_out_a !== '0 || btf_out_b !== '0) begin
      n_err++;
      $display("FAIL rstmid_clear: got vld=%0b a=%0d b=%0d want 0 0 0",
               out_valid, btf_out_a, btf_out_b);
    end
    for (int k = 0; k < LAT + 3; k++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL rstmid_stale step %0d: got %0b want 0", k, out_valid);
      end
    end
    step(1, 14'd100, 14'd4000, 14'd9999, 0, 0, 0);
    for (int k = 0; k < LAT + 1; k++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (out_valid !== m.vld) begin
        n_err++; $display("FAIL rstmid_vld step %0d: got %0b want %0b", k, out_valid, m.vld);
      end
      if (m.vld) begin
        n_vec++;
        if (btf_out_a !== m.a || btf_out_b !== m.b) begin
          n_err++;
          $display("FAIL rstmid_data: got a=%0d b=%0d want a=%0d b=%0d",
                   btf_out_a, btf_out_b, m.a, m.b);
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    stall    = 1'b0;
    intt     = 1'b0;
    in_valid = 1'b0;
    btf_in_a = '0;
    btf_in_b = '0;
    btf_in_w = '0;
    q        = LOGQ'(Q);
    mu       = (LOGQ+1)'(MU);
    m        = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
